// File: rtl/apb_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_csr_pkg
// Brief    : Shared register offsets, FSM encoding and PARAM word builder
//            for the APB-to-CSR indirect access bridge.
// Revision : 1.0
// ============================================================================
package apb_csr_pkg;

  localparam logic [1:0] OFS_ADDR  = 2'd0;
  localparam logic [1:0] OFS_DATA  = 2'd1;
  localparam logic [1:0] OFS_CTRL  = 2'd2;
  localparam logic [1:0] OFS_PARAM = 2'd3;

  localparam int CTRL_AINC_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Self-description word read back from the PARAM register.
  function automatic logic [31:0] param_word(input int aw, input int lat);
    logic [31:0] w_aw;
    logic [31:0] w_lat;
    w_aw       = aw;
    w_lat      = lat;
    param_word = {8'h00, w_lat[7:0], w_aw[7:0], 8'h01};
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_csr_bridge_ai.sv
`default_nettype none
// ============================================================================
// Module   : apb_csr_bridge_ai
// Brief    : APB3 slave giving indirect access to a fixed-latency CSR space
//            through ADDR/DATA registers, with optional address auto-increment.
// Revision : 1.0
// ============================================================================
module apb_csr_bridge_ai
  import apb_csr_pkg::*;
#(
  parameter int CSR_AW    = 14,
  parameter int RD_LAT    = 1,
  parameter int AINC_STEP = 1
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [CSR_AW-1:0] CSR_A,
  output logic [31:0]       CSR_DW,
  output logic              CSR_WE,
  input  logic [31:0]       CSR_DR
);

  localparam int                CNT_W      = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CSR_AW-1:0] ADDR_STEP  = CSR_AW'(AINC_STEP);
  localparam logic [31:0]       PARAM_WORD = param_word(CSR_AW, RD_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CSR_AW-1:0] r_addr;
  logic [CSR_AW-1:0] w_addr_nxt;
  logic              r_ainc;
  logic              w_ainc_nxt;
  logic [31:0]       r_csr_dw;
  logic [31:0]       w_csr_dw_nxt;
  logic              r_csr_we;
  logic              w_csr_we_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rdata_nxt;

  logic              w_access;
  logic [1:0]        w_reg;
  logic              w_data_sel;
  logic              w_pready;
  logic              w_unused_paddr;

  assign w_access       = PSEL & PENABLE;
  assign w_reg          = PADDR[3:2];
  assign w_data_sel     = (w_reg == OFS_DATA);
  assign w_unused_paddr = ^{PADDR[31:4], PADDR[1:0]};

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_ainc   <= 1'b0;
      r_csr_dw <= '0;
      r_csr_we <= 1'b0;
      r_cnt    <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_ainc   <= w_ainc_nxt;
      r_csr_dw <= w_csr_dw_nxt;
      r_csr_we <= w_csr_we_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  // Transfers are only accepted from IDLE; a DATA access then runs the CSR
  // handshake while PSEL/PENABLE are held stable by the APB master.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_ainc_nxt   = r_ainc;
    w_csr_dw_nxt = r_csr_dw;
    w_csr_we_nxt = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_rdata_nxt  = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_data_sel) begin
            if (PWRITE) begin
              w_csr_dw_nxt = PWDATA;
              w_csr_we_nxt = 1'b1;
              w_state_nxt  = ST_WR;
            end else begin
              w_cnt_nxt   = CNT_LOAD;
              w_state_nxt = ST_RD;
            end
          end else if (PWRITE) begin
            if (w_reg == OFS_ADDR) begin
              w_addr_nxt = PWDATA[CSR_AW-1:0];
            end else if (w_reg == OFS_CTRL) begin
              w_ainc_nxt = PWDATA[CTRL_AINC_BIT];
            end
          end
        end
      end
      ST_WR: begin
        w_state_nxt = ST_DONE;
      end
      ST_RD: begin
        if (r_cnt == '0) begin
          w_rdata_nxt = CSR_DR;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        // Address advances once the CSR access is fully complete, wrapping silently.
        if (r_ainc) begin
          w_addr_nxt = r_addr + ADDR_STEP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_pready = (r_state == ST_IDLE) ? !(w_access & w_data_sel)
                                         : (r_state == ST_DONE);

  always_comb begin
    PRDATA = '0;
    if (w_access && !PWRITE && w_pready) begin
      case (w_reg)
        OFS_ADDR:  PRDATA = 32'(r_addr);
        OFS_DATA:  PRDATA = r_rdata;
        OFS_CTRL:  PRDATA = {31'b0, r_ainc};
        default:   PRDATA = PARAM_WORD;
      endcase
    end
  end

  assign PREADY  = w_pready;
  assign PSLVERR = w_pready & w_access & PWRITE & (w_reg == OFS_PARAM);
  assign CSR_A   = r_addr;
  assign CSR_DW  = r_csr_dw;
  assign CSR_WE  = r_csr_we;

endmodule
`default_nettype wire

// File: tb/tb_apb_csr_bridge_ai.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_csr_bridge_ai
// Brief    : Self-checking scoreboard bench for apb_csr_bridge_ai (RD_LAT=3).
// Revision : 1.0
// ============================================================================
module tb_apb_csr_bridge_ai;

  localparam int AW  = 14;
  localparam int LAT = 3;

  logic          PCLK = 1'b0;
  logic          PRESERN;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic [AW-1:0] CSR_A;
  logic [31:0]   CSR_DW, CSR_DR;
  logic          CSR_WE;

  apb_csr_bridge_ai #(.CSR_AW(AW), .RD_LAT(LAT), .AINC_STEP(1)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .CSR_A(CSR_A), .CSR_DW(CSR_DW),
    .CSR_WE(CSR_WE), .CSR_DR(CSR_DR)
  );

  always #5 PCLK = ~PCLK;

  // CSR slave model: returns the inverted address, zero-extended.
  assign CSR_DR = {{(32-AW){1'b0}}, ~CSR_A};

  typedef struct { logic [31:0] rdata; logic err; int waits; } apb_rsp_t;
  typedef struct { logic [AW-1:0] a; logic [31:0] d; } csr_wr_t;

  apb_rsp_t apb_exp_q[$];
  apb_rsp_t apb_obs_q[$];
  csr_wr_t  csr_exp_q[$];
  csr_wr_t  csr_obs_q[$];

  int checks = 0;
  int errors = 0;

  always @(negedge PCLK) begin
    if (CSR_WE === 1'b1) csr_obs_q.push_back(csr_wr_t'{a: CSR_A, d: CSR_DW});
  end

  // Called at posedge+1; leaves the bus idle at posedge+1 after completion.
  task automatic apb_xfer(input logic wr, input logic [1:0] idx, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
    apb_rsp_t r;
    apb_exp_q.push_back(apb_rsp_t'{rdata: exp_rd, err: exp_err, waits: exp_waits});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {28'h0, idx, 2'b00}; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    r.waits = 0; r.rdata = 32'h0; r.err = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        r.rdata = PRDATA; r.err = PSLVERR;
        break;
      end
      r.waits++;
    end
    apb_obs_q.push_back(r);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (CSR_A !== '0) begin errors++; $display("FAIL reset CSR_A: got %h required 0", CSR_A); end
    checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      errors++; $display("FAIL reset PREADY/PSLVERR: got %b/%b required 1/0", PREADY, PSLVERR);
    end
    checks++;
    if (CSR_WE !== 1'b0 || CSR_DW !== 32'h0 || PRDATA !== 32'h0) begin
      errors++; $display("FAIL reset CSR_WE/CSR_DW/PRDATA: got %b/%h/%h required 0/0/0", CSR_WE, CSR_DW, PRDATA);
    end
  endtask

  task automatic test_data_write;
    apb_rsp_t e, o; csr_wr_t ce, co;
    apb_xfer(1'b1, 2'd0, 32'h0000_0123, 32'h0, 1'b0, 0);
    csr_exp_q.push_back(csr_wr_t'{a: 14'h0123, d: 32'hDEAD_BEEF});
    apb_xfer(1'b1, 2'd1, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_0123, 1'b0, 0);
    checks++;
    if (CSR_DW !== 32'hDEAD_BEEF || CSR_WE !== 1'b0) begin
      errors++; $display("FAIL data_write hold: CSR_DW=%h CSR_WE=%b required DEADBEEF/0", CSR_DW, CSR_WE);
    end
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL data_write apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL data_write apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
    checks++;
    if (csr_obs_q.size() != csr_exp_q.size()) begin
      errors++; $display("FAIL data_write csr_we count: got %0d required %0d", csr_obs_q.size(), csr_exp_q.size());
    end
    while (csr_exp_q.size() != 0 && csr_obs_q.size() != 0) begin
      ce = csr_exp_q.pop_front(); co = csr_obs_q.pop_front(); checks++;
      if (co.a !== ce.a || co.d !== ce.d) begin
        errors++; $display("FAIL data_write csr: got a=%h d=%h required a=%h d=%h", co.a, co.d, ce.a, ce.d);
      end
    end
    csr_exp_q.delete(); csr_obs_q.delete();
  endtask

  task automatic test_data_read;
    apb_rsp_t e, o;
    apb_xfer(1'b1, 2'd0, 32'h0000_0040, 32'h0, 1'b0, 0);
    apb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_3FBF, 1'b0, LAT + 1);
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_0040, 1'b0, 0);
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL data_read apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL data_read apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
    checks++;
    if (csr_obs_q.size() != 0) begin errors++; $display("FAIL data_read csr_we on read: got %0d pulses required 0", csr_obs_q.size()); end
    csr_obs_q.delete();
  endtask

  task automatic test_ainc_wrap;
    apb_rsp_t e, o; csr_wr_t ce, co;
    logic [AW-1:0] a;
    apb_xfer(1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    apb_xfer(1'b0, 2'd2, 32'h0, 32'h0000_0001, 1'b0, 0);
    apb_xfer(1'b1, 2'd0, 32'h0000_3FFE, 32'h0, 1'b0, 0);
    a = 14'h3FFE;
    for (int i = 0; i < 4; i++) begin
      csr_exp_q.push_back(csr_wr_t'{a: a, d: 32'hA5A5_0000 + i});
      apb_xfer(1'b1, 2'd1, 32'hA5A5_0000 + i, 32'h0, 1'b0, 2);
      a = a + 14'd1;
    end
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_0002, 1'b0, 0);
    apb_xfer(1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0, 1'b0, 0);
    apb_xfer(1'b0, 2'd2, 32'h0, 32'h0000_0000, 1'b0, 0);
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL ainc apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL ainc apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
    checks++;
    if (csr_obs_q.size() != csr_exp_q.size()) begin
      errors++; $display("FAIL ainc csr_we count: got %0d required %0d", csr_obs_q.size(), csr_exp_q.size());
    end
    while (csr_exp_q.size() != 0 && csr_obs_q.size() != 0) begin
      ce = csr_exp_q.pop_front(); co = csr_obs_q.pop_front(); checks++;
      if (co.a !== ce.a || co.d !== ce.d) begin
        errors++; $display("FAIL ainc csr: got a=%h d=%h required a=%h d=%h", co.a, co.d, ce.a, ce.d);
      end
    end
    csr_exp_q.delete(); csr_obs_q.delete();
  endtask

  task automatic test_param;
    apb_rsp_t e, o;
    apb_xfer(1'b1, 2'd0, 32'h0000_1555, 32'h0, 1'b0, 0);
    apb_xfer(1'b1, 2'd2, 32'h0000_0001, 32'h0, 1'b0, 0);
    apb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_1555, 1'b0, 0);
    apb_xfer(1'b0, 2'd2, 32'h0, 32'h0000_0001, 1'b0, 0);
    apb_xfer(1'b0, 2'd3, 32'h0, 32'h0003_0E01, 1'b0, 0);
    apb_xfer(1'b1, 2'd2, 32'h0, 32'h0, 1'b0, 0);
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL param apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL param apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
    checks++;
    if (csr_obs_q.size() != 0) begin errors++; $display("FAIL param csr_we: got %0d pulses required 0", csr_obs_q.size()); end
    csr_obs_q.delete();
  endtask

  task automatic test_addr_mask;
    apb_rsp_t e, o;
    apb_xfer(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_3FFF, 1'b0, 0);
    apb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0000, 1'b0, LAT + 1);
    apb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0000, 1'b0, LAT + 1);
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_3FFF, 1'b0, 0);
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL addr_mask apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL addr_mask apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    apb_rsp_t e, o; csr_wr_t ce, co;
    apb_xfer(1'b1, 2'd0, 32'h0000_0100, 32'h0, 1'b0, 0);
    csr_exp_q.push_back(csr_wr_t'{a: 14'h0100, d: 32'h1111_2222});
    apb_xfer(1'b1, 2'd1, 32'h1111_2222, 32'h0, 1'b0, 2);
    csr_exp_q.push_back(csr_wr_t'{a: 14'h0100, d: 32'h3333_4444});
    apb_xfer(1'b1, 2'd1, 32'h3333_4444, 32'h0, 1'b0, 2);
    apb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_3EFF, 1'b0, LAT + 1);
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_0100, 1'b0, 0);
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL back_to_back apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL back_to_back apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
    checks++;
    if (csr_obs_q.size() != csr_exp_q.size()) begin
      errors++; $display("FAIL back_to_back csr_we count: got %0d required %0d", csr_obs_q.size(), csr_exp_q.size());
    end
    while (csr_exp_q.size() != 0 && csr_obs_q.size() != 0) begin
      ce = csr_exp_q.pop_front(); co = csr_obs_q.pop_front(); checks++;
      if (co.a !== ce.a || co.d !== ce.d) begin
        errors++; $display("FAIL back_to_back csr: got a=%h d=%h required a=%h d=%h", co.a, co.d, ce.a, ce.d);
      end
    end
    csr_exp_q.delete(); csr_obs_q.delete();
  endtask

  task automatic test_reset_mid_rd;
    apb_rsp_t e, o;
    apb_xfer(1'b1, 2'd0, 32'h0000_0200, 32'h0, 1'b0, 0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h4;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #2;
    PSEL = 1'b0; PENABLE = 1'b0; PRESERN = 1'b0;
    #1;
    checks++;
    if (CSR_A !== '0 || PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      errors++; $display("FAIL mid_rd reset bus: CSR_A=%h PREADY=%b PSLVERR=%b PRDATA=%h required 0/1/0/0",
                         CSR_A, PREADY, PSLVERR, PRDATA);
    end
    checks++;
    if (CSR_DW !== 32'h0 || CSR_WE !== 1'b0) begin
      errors++; $display("FAIL mid_rd reset csr: CSR_DW=%h CSR_WE=%b required 0/0", CSR_DW, CSR_WE);
    end
    @(posedge PCLK);
    @(negedge PCLK);
    PRESERN = 1'b1;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 2'd0, 32'h0, 32'h0000_0000, 1'b0, 0);
    apb_xfer(1'b0, 2'd2, 32'h0, 32'h0000_0000, 1'b0, 0);
    apb_xfer(1'b1, 2'd0, 32'h0000_0040, 32'h0, 1'b0, 0);
    apb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_3FBF, 1'b0, LAT + 1);
    while (apb_exp_q.size() != 0) begin
      e = apb_exp_q.pop_front(); checks++;
      if (apb_obs_q.size() == 0) begin errors++; $display("FAIL mid_rd apb: no response, required %h", e.rdata); end
      else begin
        o = apb_obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
          errors++; $display("FAIL mid_rd apb: got rdata=%h err=%b waits=%0d required rdata=%h err=%b waits=%0d",
                             o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
        end
      end
    end
    checks++;
    if (csr_obs_q.size() != 0) begin errors++; $display("FAIL mid_rd csr_we: got %0d pulses required 0", csr_obs_q.size()); end
    csr_obs_q.delete();
  endtask

  initial begin
    PRESERN = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
    #1 PRESERN = 1'b0;
    #1 test_reset;
    #10 PRESERN = 1'b1;
    @(posedge PCLK); #1;
    test_data_write;
    test_data_read;
    test_ainc_wrap;
    test_param;
    test_addr_mask;
    test_back_to_back;
    test_reset_mid_rd;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
